// File: rtl/char_fifo_pkg.sv
// Shared constants for the char_fifo block: active-low strobe levels,
// default depth and the pointer width derived from it.
package char_fifo_pkg;

    // Active-low strobe levels used across the board.
    localparam logic nT = 1'b0;
    localparam logic nF = 1'b1;

    // Default log2 entry count and matching pointer width (one extra MSB
    // distinguishes full from empty when the addresses coincide).
    localparam int CHAR_FIFO_DEPTH_LOG2 = 3;

    function automatic int ptr_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    localparam int CHAR_FIFO_PTR_W = ptr_width(CHAR_FIFO_DEPTH_LOG2);

    // True when an active-low strobe is asserted.
    function automatic logic asserted(input logic n_sig);
        return n_sig == nT;
    endfunction

endpackage

// File: rtl/char_fifo_mem.sv
// Storage array for char_fifo: one synchronous write port and one
// asynchronous read port. Contents are never cleared.
module char_fifo_mem #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Capture the incoming character into the addressed slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/char_fifo.sv
// char_fifo: first-word-fall-through byte FIFO behind chargen.
// Pointers, flags and sticky error bits live here; storage is char_fifo_mem.
// Optional build macro: CHAR_FIFO_ALMOST_FULL_EN adds the n_afull output.
module char_fifo
    import char_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = CHAR_FIFO_DEPTH_LOG2,
    parameter int WIDTH      = 8,
    parameter int AF_LEVEL   = 6
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  n_wr,
    input  logic [WIDTH-1:0]      din,
    input  logic                  n_rd,
    output logic [WIDTH-1:0]      dout,
    output logic                  n_empty,
    output logic                  n_full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  n_ovf,
`ifdef CHAR_FIFO_ALMOST_FULL_EN
    output logic                  n_afull,
`endif
    output logic                  n_udf
);

    localparam int PTR_W = ptr_width(DEPTH_LOG2);

    // Elaboration guard on the almost-full threshold.
    if (AF_LEVEL < 1 || AF_LEVEL > (1 << DEPTH_LOG2)) begin : g_af_range
        $error("char_fifo: AF_LEVEL outside 1..2**DEPTH_LOG2");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] dout_hold;
    logic             ovf_r;
    logic             udf_r;
    logic             is_empty;
    logic             is_full;
    logic             wr_req;
    logic             rd_req;
    logic             wr_go;
    logic             rd_go;
    logic             mem_we;

    assign is_empty = (wr_ptr == rd_ptr);
    assign is_full  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                      (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);

    assign wr_req = asserted(n_wr);
    assign rd_req = asserted(n_rd);

    // A full FIFO still accepts a write when a pop frees the head slot on
    // the same edge; an empty FIFO never pops, so a concurrent write just
    // lands and shows up on dout one cycle later.
    assign wr_go  = wr_req && (!is_full || rd_req);
    assign rd_go  = rd_req && !is_empty;
    assign mem_we = wr_go && (n_rst == nF);

    char_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (din),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (head)
    );

    // Advance pointers on accepted writes/pops; reset overrides strobes.
    always_ff @(posedge clk) begin
        if (n_rst == nT) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_go) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_go) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Sticky error flags: overflow on a dropped write, underflow on a
    // read of an empty FIFO with no write alongside it.
    always_ff @(posedge clk) begin
        if (n_rst == nT) begin
            ovf_r <= nF;
            udf_r <= nF;
        end else begin
            if (wr_req && !rd_req && is_full) begin
                ovf_r <= nT;
            end
            if (rd_req && !wr_req && is_empty) begin
                udf_r <= nT;
            end
        end
    end

    // Remember the last head shown so dout holds steady once drained.
    always_ff @(posedge clk) begin
        if (n_rst == nT) begin
            dout_hold <= '0;
        end else if (!is_empty) begin
            dout_hold <= head;
        end
    end

    assign dout    = is_empty ? dout_hold : head;
    assign count   = wr_ptr - rd_ptr;
    assign n_empty = is_empty ? nT : nF;
    assign n_full  = is_full  ? nT : nF;
    assign n_ovf   = ovf_r;
    assign n_udf   = udf_r;

`ifdef CHAR_FIFO_ALMOST_FULL_EN
    localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(AF_LEVEL);

    assign n_afull = (count >= AF_THRESH) ? nT : nF;
`endif

endmodule

// File: tb/tb_char_fifo.sv
// Self-checking bench for char_fifo: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_char_fifo;
    import char_fifo_pkg::*;

    localparam int DEPTH = 8;

    logic                       clk = 1'b0;
    logic                       n_rst;
    logic                       n_wr;
    logic                       n_rd;
    logic [7:0]                 din;
    logic [7:0]                 dout;
    logic                       n_empty;
    logic                       n_full;
    logic [CHAR_FIFO_PTR_W-1:0] count;
    logic                       n_ovf;
    logic                       n_udf;
`ifdef CHAR_FIFO_ALMOST_FULL_EN
    logic                       n_afull;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    byte unsigned q[$];
    logic         m_ovf;
    logic         m_udf;
    logic [7:0]   m_hold;
    bit           m_valid = 1'b0;

    always #5 clk = ~clk;

    char_fifo dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .n_wr    (n_wr),
        .din     (din),
        .n_rd    (n_rd),
        .dout    (dout),
        .n_empty (n_empty),
        .n_full  (n_full),
        .count   (count),
        .n_ovf   (n_ovf),
`ifdef CHAR_FIFO_ALMOST_FULL_EN
        .n_afull (n_afull),
`endif
        .n_udf   (n_udf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: applies the FIFO rules to the queue at each rising edge.
    task automatic model_step();
        int n;
        bit w;
        bit r;
        n = q.size();
        w = (n_wr == 1'b0);
        r = (n_rd == 1'b0);
        if (n_rst == 1'b0) begin
            q.delete();
            m_ovf   = 1'b1;
            m_udf   = 1'b1;
            m_hold  = 8'h00;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (n > 0) m_hold = q[0];
            if (r && n > 0) void'(q.pop_front());
            if (w && (n < DEPTH || r)) q.push_back(din);
            if (w && !r && n == DEPTH) m_ovf = 1'b0;
            if (r && !w && n == 0) m_udf = 1'b0;
        end
    endtask

    always @(posedge clk) model_step();

    task automatic compare_all();
        int n;
        logic [7:0] exp_dout;
        n = q.size();
        exp_dout = (n > 0) ? q[0] : m_hold;
        check("cyc_count",   32'(count),   32'(n));
        check("cyc_n_empty", 32'(n_empty), 32'(n != 0));
        check("cyc_n_full",  32'(n_full),  32'(n != DEPTH));
        check("cyc_dout",    32'(dout),    32'(exp_dout));
        check("cyc_n_ovf",   32'(n_ovf),   32'(m_ovf));
        check("cyc_n_udf",   32'(n_udf),   32'(m_udf));
`ifdef CHAR_FIFO_ALMOST_FULL_EN
        check("cyc_n_afull", 32'(n_afull), 32'(n < 6));
`endif
    endtask

    // Per-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) compare_all();
    end

    // One clock with the given strobes (arguments are active-high requests).
    task automatic step(input bit wr, input bit rd, input logic [7:0] d);
        n_wr = wr ? 1'b0 : 1'b1;
        n_rd = rd ? 1'b0 : 1'b1;
        din  = d;
        @(posedge clk);
        #1;
        n_wr = 1'b1;
        n_rd = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0;
        n_wr  = 1'b1;
        n_rd  = 1'b1;
        din   = 8'h00;

        // Reset
        step(0, 0, 8'h00);
        n_rst = 1'b1;
        check("rst_count",   32'(count),   32'd0);
        check("rst_n_empty", 32'(n_empty), 32'd0);
        check("rst_n_full",  32'(n_full),  32'd1);
        check("rst_n_ovf",   32'(n_ovf),   32'd1);
        check("rst_n_udf",   32'(n_udf),   32'd1);
        check("rst_dout",    32'(dout),    32'd0);

        // Chargen chain: "a","b","c"
        step(1, 0, 8'h61);
        check("chain_lat_dout", 32'(dout), 32'h61);
        step(1, 0, 8'h62);
        step(1, 0, 8'h63);
        check("chain_count", 32'(count), 32'd3);
        check("chain_head",  32'(dout),  32'h61);
        step(0, 1, 8'h00);
        check("chain_rd1", 32'(dout), 32'h62);
        step(0, 1, 8'h00);
        check("chain_rd2", 32'(dout), 32'h63);
        step(0, 1, 8'h00);
        check("chain_empty", 32'(n_empty), 32'd0);
        check("chain_hold",  32'(dout),    32'h63);

        // Fill and overflow
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 8'(8'h41 + i));
            if (i == 6) check("fill_not_full7", 32'(n_full), 32'd1);
            if (i == 7) check("fill_full8",     32'(n_full), 32'd0);
        end
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag",  32'(n_ovf), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("fill_order", 32'(dout), 32'(8'h41 + i));
            step(0, 1, 8'h00);
        end
        check("fill_drained", 32'(n_empty), 32'd0);

        // Wrap: 5 in/out then 6 in/out
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h30 + i));
        for (int i = 0; i < 5; i++) begin
            check("wrap_a", 32'(dout), 32'(8'h30 + i));
            step(0, 1, 8'h00);
        end
        for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h35 + i));
        check("wrap_count6", 32'(count), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("wrap_b", 32'(dout), 32'(8'h35 + i));
            step(0, 1, 8'h00);
        end
        check("wrap_count0", 32'(count), 32'd0);

        // Simultaneous read+write while full
        for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h50 + i));
        check("sim_full_pre", 32'(n_full), 32'd0);
        step(1, 1, 8'h58);
        check("sim_full_count", 32'(count),  32'd8);
        check("sim_full_head",  32'(dout),   32'h51);
        check("sim_full_flag",  32'(n_full), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("sim_full_order", 32'(dout), 32'(8'h51 + i));
            step(0, 1, 8'h00);
        end

        // Simultaneous read+write while empty
        step(1, 1, 8'h60);
        check("sim_empty_count", 32'(count),   32'd1);
        check("sim_empty_udf",   32'(n_udf),   32'd1);
        check("sim_empty_dout",  32'(dout),    32'h60);
        check("sim_empty_ne",    32'(n_empty), 32'd1);
        step(0, 1, 8'h00);

        // Underflow, then reset mid-operation with strobes asserted
        step(0, 1, 8'h00);
        check("udf_flag", 32'(n_udf), 32'd0);
        for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h70 + i));
        check("pre_rst_count", 32'(count), 32'd4);
        n_rst = 1'b0;
        step(1, 1, 8'hEE);
        n_rst = 1'b1;
        check("mid_rst_count",   32'(count),   32'd0);
        check("mid_rst_n_empty", 32'(n_empty), 32'd0);
        check("mid_rst_n_full",  32'(n_full),  32'd1);
        check("mid_rst_n_ovf",   32'(n_ovf),   32'd1);
        check("mid_rst_n_udf",   32'(n_udf),   32'd1);
        check("mid_rst_dout",    32'(dout),    32'd0);
        step(0, 0, 8'h00);
        check("mid_rst_idle_dout", 32'(dout), 32'd0);

`ifdef CHAR_FIFO_ALMOST_FULL_EN
        // Almost-full threshold
        check("afull_rst", 32'(n_afull), 32'd1);
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h80 + i));
        check("afull_5", 32'(n_afull), 32'd1);
        step(1, 0, 8'h85);
        check("afull_6", 32'(n_afull), 32'd0);
        step(0, 1, 8'h00);
        check("afull_rd", 32'(n_afull), 32'd1);
`endif

        step(0, 0, 8'h00);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/char_fifo.md
Name: char_fifo

Overview:
Byte FIFO sitting directly downstream of chargen: captures each character chargen drives on its 8-bit port and buffers it for a slower consumer (UART/host read side). Single clock domain; strobes active-low like the rest of the board. First-word-fall-through read port so the consumer sees the head character without a read latency.

Parameters:
DEPTH_LOG2, 3, log2 of entry count (default 8 entries)
WIDTH, 8, data width in bits
AF_LEVEL, 6, almost-full threshold in entries (used only with optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
n_rst  input  1  synchronous active-low reset
n_wr  input  1  active-low write strobe, sampled every clk
din  input  WIDTH  write data (connects to chargen port)
n_rd  input  1  active-low read/pop strobe, sampled every clk
dout  output  WIDTH  head entry (FWFT)
n_empty  output  1  low when FIFO holds 0 entries
n_full  output  1  low when FIFO holds 2**DEPTH_LOG2 entries
count  output  DEPTH_LOG2+1  current occupancy
n_ovf  output  1  sticky, low after write attempted while full
n_udf  output  1  sticky, low after read attempted while empty

Behaviour:
- Reset (n_rst low at rising clk): wr_ptr=rd_ptr=0, count=0, n_empty=0, n_full=1, n_ovf=1, n_udf=1, dout=0. Memory contents not cleared. Reset wins over any strobe in the same cycle.
- Pointers DEPTH_LOG2+1 bits wide; extra MSB distinguishes full/empty; address = low DEPTH_LOG2 bits; natural wrap at 2**DEPTH_LOG2.
- Write: n_wr low at rising clk and not full -> mem[wr_ptr]<=din, wr_ptr+1. One write per cycle while held low (level-sampled, no edge detect).
- Read: n_rd low at rising clk and not empty -> rd_ptr+1; dout shows new head next cycle.
- dout = mem[rd_ptr] whenever not empty; held at last value (0 after reset) when empty.
- Flags derived combinationally from registered pointers: empty when ptrs equal; full when addresses equal and MSBs differ; count = wr_ptr - rd_ptr (mod 2**(DEPTH_LOG2+1)).
- Simultaneous read+write, not empty and not full: both performed, count unchanged.
- Simultaneous read+write when full: read performed, write also accepted (slot freed same edge); count stays full.
- Simultaneous read+write when empty: write accepted, read ignored, n_udf NOT asserted; no bypass, data visible on dout the next cycle.
- Write while full (no concurrent read): dropped, state unchanged, n_ovf<=0.
- Read while empty (no concurrent write): ignored, n_udf<=0.
- n_ovf/n_udf clear only on reset.
- Write-to-dout latency: 1 clk (write at edge N, n_empty high and dout valid after edge N).

Optional Feature:
CHAR_FIFO_ALMOST_FULL_EN: when defined, adds output n_afull (1 bit), low when count >= AF_LEVEL, registered-free (combinational from count); reset value 1. When undefined, port and logic absent; AF_LEVEL unused.

Decomposition:
- Shared include common.v: existing nT/nF active-low constants; add CHAR_FIFO_DEPTH_LOG2 default and pointer width constant.
- Sub-module char_fifo_mem: 2**DEPTH_LOG2 x WIDTH array, sync write port, async read port; control/pointers/flags stay in char_fifo.

Test Plan:
- Reset: n_rst low 1 clk -> count=0, n_empty=0, n_full=1, n_ovf=1, n_udf=1, dout=0.
- Chargen chain: chargen LASTCHAR="c" feeding din, write 3 cycles "a","b","c" -> count=3, dout="a"; 3 reads -> dout "b","c", then n_empty=0.
- Fill/overflow: 9 writes 0x41..0x49 into depth 8 -> n_full=0 after 8th, 0x49 dropped, n_ovf=0, count=8; 8 reads return 0x41..0x48.
- Wrap: write 5, read 5, write 6, read 6 (values 0x30..0x3A) -> order preserved across pointer wrap, count returns 0.
- Simultaneous: full + n_wr,n_rd low same clk -> count stays 8, head advances, new byte stored; empty + both low -> count=1, n_udf stays 1.
- Underflow + reset mid-op: read on empty -> n_udf=0; then reset with count=4 -> all outputs at reset values next clk; with CHAR_FIFO_ALMOST_FULL_EN, 6 writes -> n_afull=0, one read -> n_afull=1.
